// File: rtl/dsp_pkg.sv
// Shared Q-format helpers for the dsp_iq_* datapath blocks:
// signed range limits and the round-half-up offset for a given shift.
package dsp_pkg;

    function automatic longint sMax(input int width);
        return (longint'(1) <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic longint sMin(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

    // Half an output LSB expressed in input LSBs; a zero shift needs no rounding.
    function automatic longint roundOffset(input int shift);
        return (shift > 0) ? (longint'(1) <<< (shift - 1)) : 64'sd0;
    endfunction

endpackage

// File: rtl/dsp_round_sat.sv
// Combinational arithmetic shift + signed saturation for one IQ component.
// Optional saturation flag output exists only when DSP_IQ_ROUND_OVF_EN is defined.
module dsp_round_sat
    import dsp_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 15
) (
    input  logic signed [IN_WIDTH:0]    i_sum,
`ifdef DSP_IQ_ROUND_OVF_EN
    output logic                        o_sat,
`endif
    output logic signed [OUT_WIDTH-1:0] o_data
);

    localparam logic signed [IN_WIDTH:0] MAX_VAL = (IN_WIDTH + 1)'(sMax(OUT_WIDTH));
    localparam logic signed [IN_WIDTH:0] MIN_VAL = (IN_WIDTH + 1)'(sMin(OUT_WIDTH));

    logic signed [IN_WIDTH:0] w_shifted;
    logic                     w_sat;

    assign w_shifted = i_sum >>> SHIFT;

    // The offset was already added upstream, so the floor shift completes round-half-up.
    always_comb begin
        o_data = w_shifted[OUT_WIDTH-1:0];
        w_sat  = 1'b0;
        if (w_shifted > MAX_VAL) begin
            o_data = MAX_VAL[OUT_WIDTH-1:0];
            w_sat  = 1'b1;
        end else if (w_shifted < MIN_VAL) begin
            o_data = MIN_VAL[OUT_WIDTH-1:0];
            w_sat  = 1'b1;
        end
    end

`ifdef DSP_IQ_ROUND_OVF_EN
    assign o_sat = w_sat;
`endif

endmodule

// File: rtl/dsp_iq_round.sv
// Two-stage round/shift/saturate pipeline for complex products, AXI-stream on both sides.
// Define DSP_IQ_ROUND_OVF_EN to add the output_ovf flag and the ovf_count counter.
module dsp_iq_round
    import dsp_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  input_i_tdata,
    input  logic [IN_WIDTH-1:0]  input_q_tdata,
    input  logic                 input_tvalid,
    output logic                 input_tready,
    output logic [OUT_WIDTH-1:0] output_i_tdata,
    output logic [OUT_WIDTH-1:0] output_q_tdata,
    output logic                 output_tvalid,
`ifdef DSP_IQ_ROUND_OVF_EN
    output logic                 output_ovf,
    output logic [15:0]          ovf_count,
`endif
    input  logic                 output_tready
);

    localparam logic signed [IN_WIDTH:0] ROUND_OFS = (IN_WIDTH + 1)'(roundOffset(SHIFT));

    logic                        w_s1Load;
    logic                        w_s2Load;
    logic signed [IN_WIDTH:0]    w_iSum;
    logic signed [IN_WIDTH:0]    w_qSum;
    logic signed [OUT_WIDTH-1:0] w_iRound;
    logic signed [OUT_WIDTH-1:0] w_qRound;

    logic                        r_s1Valid;
    logic signed [IN_WIDTH:0]    r_s1I;
    logic signed [IN_WIDTH:0]    r_s1Q;
    logic                        r_outValid;
    logic [OUT_WIDTH-1:0]        r_outI;
    logic [OUT_WIDTH-1:0]        r_outQ;

    // Ready ripples combinationally back from output_tready; there is no skid buffer.
    assign w_s2Load     = ~r_outValid | output_tready;
    assign w_s1Load     = ~r_s1Valid | w_s2Load;
    assign input_tready = w_s1Load;

    // One guard bit keeps the rounding add from wrapping at the positive limit.
    assign w_iSum = $signed({input_i_tdata[IN_WIDTH-1], input_i_tdata}) + ROUND_OFS;
    assign w_qSum = $signed({input_q_tdata[IN_WIDTH-1], input_q_tdata}) + ROUND_OFS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1I     <= '0;
            r_s1Q     <= '0;
        end else if (w_s1Load) begin
            r_s1Valid <= input_tvalid;
            if (input_tvalid) begin
                r_s1I <= w_iSum;
                r_s1Q <= w_qSum;
            end
        end
    end

`ifdef DSP_IQ_ROUND_OVF_EN
    logic w_iSat;
    logic w_qSat;
`endif

    dsp_round_sat #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_roundI (
        .i_sum  (r_s1I),
`ifdef DSP_IQ_ROUND_OVF_EN
        .o_sat  (w_iSat),
`endif
        .o_data (w_iRound)
    );

    dsp_round_sat #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_roundQ (
        .i_sum  (r_s1Q),
`ifdef DSP_IQ_ROUND_OVF_EN
        .o_sat  (w_qSat),
`endif
        .o_data (w_qRound)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outI     <= '0;
            r_outQ     <= '0;
        end else if (w_s2Load) begin
            r_outValid <= r_s1Valid;
            if (r_s1Valid) begin
                r_outI <= w_iRound;
                r_outQ <= w_qRound;
            end
        end
    end

    assign output_tvalid  = r_outValid;
    assign output_i_tdata = r_outI;
    assign output_q_tdata = r_outQ;

`ifdef DSP_IQ_ROUND_OVF_EN
    logic        r_outOvf;
    logic [15:0] r_ovfCount;

    // The counter sticks at all-ones rather than wrapping so a flood stays visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outOvf   <= 1'b0;
            r_ovfCount <= '0;
        end else begin
            if (w_s2Load && r_s1Valid) begin
                r_outOvf <= w_iSat | w_qSat;
            end
            if (r_outValid && output_tready && r_outOvf && (r_ovfCount != 16'hFFFF)) begin
                r_ovfCount <= r_ovfCount + 16'd1;
            end
        end
    end

    assign output_ovf = r_outOvf;
    assign ovf_count  = r_ovfCount;
`endif

endmodule

// File: doc/dsp_iq_round.md
Name: dsp_iq_round

Overview:
- Downstream companion to dsp_iq_mult. Consumes its full-precision 2*WIDTH complex product stream and returns it to working width.
- Per component: round-half-up, arithmetic right shift by SHIFT, saturate to OUT_WIDTH signed.
- Two-stage registered pipeline with AXI-stream valid/ready on both sides and full throughput.
- Sits between dsp_iq_mult output and any WIDTH-wide IQ consumer.

Parameters:
IN_WIDTH, 32, input I/Q width; signed two's complement.
OUT_WIDTH, 16, output I/Q width; signed; OUT_WIDTH <= IN_WIDTH.
SHIFT, 15, right-shift amount; 0 <= SHIFT < IN_WIDTH; default maps Q30 to Q15.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
input_i_tdata  input  IN_WIDTH  in-phase product
input_q_tdata  input  IN_WIDTH  quadrature product
input_tvalid  input  1  input beat valid
input_tready  output  1  input beat accepted when tvalid & tready
output_i_tdata  output  OUT_WIDTH  rounded/saturated I
output_q_tdata  output  OUT_WIDTH  rounded/saturated Q
output_tvalid  output  1  output beat valid
output_tready  input  1  downstream ready

Behaviour:
- Reset (async assert, sync-released logic):
  - s1_valid = 0, output_tvalid = 0.
  - output_i_tdata = output_q_tdata = 0.
  - input_tready = 1 from the first cycle after release.
  - Beats in flight are discarded; nothing is replayed after reset.
- Stage 1 (s1):
  - Each component is sign-extended to IN_WIDTH+1 bits. If SHIFT > 0, add 2^(SHIFT-1); if SHIFT = 0, add nothing.
  - Result is registered with s1_valid.
  - The extra bit guarantees no wrap, e.g. 0x7FFFFFFF + 0x4000.
- Stage 2 (output register):
  - Arithmetic shift right by SHIFT (floor), then saturate.
  - If result > 2^(OUT_WIDTH-1)-1, output max positive. If result < -2^(OUT_WIDTH-1), output max negative.
  - I and Q saturate independently.
- Rounding: net effect is round-half-toward-+inf.
  - Example: -0.5 LSB becomes 0; -0.5 LSB minus 1 input LSB becomes -1.
- Handshake:
  - s2_load = ~output_tvalid | output_tready.
  - s1_load = ~s1_valid | s2_load.
  - input_tready = s1_load. This is combinational from output_tready, which is intentional: no skid buffer is used.
  - On s2_load: output_tvalid <= s1_valid, and data loads only when s1_valid.
  - On s1_load: s1_valid <= input_tvalid, and data loads only when input_tvalid.
- Data hold: while output_tvalid = 1 and output_tready = 0, output data is held stable.
- Latency: beat accepted at edge N appears as output_tvalid at edge N+2 if unstalled.
- Throughput: one beat per cycle sustained when output_tready = 1.
- Stall: with both stages full and output_tready = 0, input_tready = 0.
  - The pipeline holds exactly 2 beats, with no loss or duplication.
- Simultaneous output pop and input push when full: both advance in the same cycle, occupancy unchanged.
- Ordering is strictly preserved. I and Q always travel together.

Optional Feature:
- Macro: DSP_IQ_ROUND_OVF_EN.
- Defined: adds two output ports.
  - output_ovf (1): registered alongside output data. High when I or Q saturated for the current output beat; meaningful only while output_tvalid.
  - ovf_count (16): counts output beats handshaked with output_ovf = 1. Saturates at 0xFFFF and clears only on rst.
- Undefined: neither port exists. Saturation behaviour is unchanged.

Decomposition:
- Shared package dsp_pkg:
  - Q-format helpers: signed max/min constants as functions of width.
  - Rounding-offset function of SHIFT, returning 0 when SHIFT = 0.
- One natural sub-module: dsp_round_sat.
  - Combinational shift + saturate for a single component.
  - Instantiated twice (I and Q) in stage 2.
- Handshake logic stays in the top.

Test Plan:
1. Default params, tready = 1: I = 0x3FFF8000, Q = 0xC0000000 -> I = 0x7FFF, Q = 0x8000, output_tvalid exactly 2 cycles after accept.
2. Rounding, I in sequence 0x00004000, 0x00003FFF, 0xFFFFC000, 0xFFFFBFFF -> 0x0001, 0x0000, 0x0000, 0xFFFF; Q mirrors with same results.
3. Saturation: I = 0x7FFFFFFF, Q = 0x80000000 -> 0x7FFF, 0x8000. With DSP_IQ_ROUND_OVF_EN: output_ovf = 1 and ovf_count 0 -> 1; a following in-range beat gives output_ovf = 0.
4. Backpressure: 8 beats (I = k<<15, k = 1..8) with output_tready toggling every cycle -> outputs 1..8 in order, none lost or duplicated. input_tready = 0 whenever both stages are full and tready is low; data stable while stalled.
5. Throughput: 100 back-to-back beats, tready = 1 -> 100 outputs on consecutive cycles, first at +2, input_tready never drops.
6. Reset mid-stream: rst pulse with 2 beats in flight -> output_tvalid = 0 during reset with no stale beat afterwards; next accepted beat emerges with 2-cycle latency.
